// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and alignment helper for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } lsu_size_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_WRITE  = 2'b10,
        S_DONE   = 2'b11
    } lsu_state_t;

    // The illegal size is folded in here so one flag covers every
    // request that must not touch memory.
    function automatic logic is_misaligned(input lsu_size_t size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// rtl/lsu_lane_mux.sv - combinational load lane extract/extend and store lane merge
// Ports:
//   word_i   : current memory word
//   off_i    : byte offset within the word
//   size_i   : access size
//   signed_i : sign-extend sub-word loads
//   wdata_i  : right-aligned store data
//   load_o   : extracted, extended load value
//   merge_o  : word_i with the addressed lane(s) replaced by wdata_i
module lsu_lane_mux
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  lsu_size_t   size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = word_i[{off_i, 3'b000} +: 8];
        half_v  = off_i[1] ? word_i[31:16] : word_i[15:0];
        load_o  = word_i;
        merge_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                load_o = {{24{signed_i & byte_v[7]}}, byte_v};
                merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_o = {{16{signed_i & half_v[15]}}, half_v};
                if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
                else          merge_o[15:0]  = wdata_i[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store unit over a word-wide data memory
// Optional feature macro: LSU_RANGE_CHECK_EN (word address >= MEM_WORDS reported as error).
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_we/size/signed/addr/wdata : request fields
//   resp_valid/rdata/err       : one-cycle completion pulse with result
//   mem_we/mem_addr/mem_d      : data memory write port and word address
//   mem_q                      : data memory read data, combinational from mem_addr
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [15:0]       mem_addr,
    output logic [31:0]       mem_d,
    input  logic [31:0]       mem_q
);

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    lsu_size_t         size_q, size_d;
    logic              signed_q, signed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       merge_q, merge_d;

    logic [31:0] load_v, merge_v;
    logic        over_range, range_err, req_err;
    logic        mem_we_c;
    logic [31:0] mem_d_c;

    lsu_lane_mux u_lane_mux (
        .word_i   (mem_q),
        .off_i    (addr_q[1:0]),
        .size_i   (size_q),
        .signed_i (signed_q),
        .wdata_i  (wdata_q),
        .load_o   (load_v),
        .merge_o  (merge_v)
    );

    assign over_range = 32'(addr_q[ADDR_W-1:2]) >= 32'(MEM_WORDS);
`ifdef LSU_RANGE_CHECK_EN
    assign range_err = over_range;
`else
    logic unused_range;
    assign unused_range = over_range;
    assign range_err    = 1'b0;
`endif
    assign req_err = is_misaligned(size_q, addr_q[1:0]) | range_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            merge_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            merge_q  <= merge_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        merge_d  = merge_q;
        mem_we_c = 1'b0;
        mem_d_c  = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = lsu_size_t'(req_size);
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    state_d  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (req_err) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end else if (!we_q) begin
                    rdata_d = load_v;
                    state_d = S_DONE;
                end else if (size_q == SZ_WORD) begin
                    mem_we_c = 1'b1;
                    mem_d_c  = wdata_q;
                    state_d  = S_DONE;
                end else begin
                    // Sub-word store: latch the merged word now, write it next cycle.
                    merge_d = merge_v;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we_c = 1'b1;
                mem_d_c  = merge_q;
                state_d  = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Write enable is gated by reset so a reset landing mid-access commits nothing.
    assign mem_we     = mem_we_c & ~rst;
    assign mem_d      = rst ? 32'd0 : mem_d_c;
    assign mem_addr   = 16'(addr_q[ADDR_W-1:2]);
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign resp_rdata = (state_q == S_DONE) ? rdata_q : 32'd0;
    assign resp_err   = (state_q == S_DONE) ? err_q : 1'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_d;
    logic [31:0] mem_q;

    logic        clr;
    logic [31:0] dmem    [1024];
    logic [31:0] ref_mem [1024];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= 32'd0;
        end else if (mem_we) begin
            dmem[mem_addr[9:0]] <= mem_d;
        end
    end
    assign mem_q = dmem[mem_addr[9:0]];

    load_store_unit #(.ADDR_W(16), .MEM_WORDS(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_d      (mem_d),
        .mem_q      (mem_q)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [15:0] a, input logic [31:0] wd);
        int          idx, off, lat, exp_lat, we_cnt, exp_we_cnt;
        logic [31:0] w, v, mask, exp_rd, got_rd;
        logic        err, got, got_err;
        idx = int'(a >> 2) % 1024;
        off = int'(a % 4);
        w   = ref_mem[idx];
        err = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
`ifdef LSU_RANGE_CHECK_EN
        if (int'(a >> 2) >= 1024) err = 1'b1;
`endif
        exp_rd = 32'd0; exp_lat = 2; exp_we_cnt = 0;
        if (!err && !we) begin
            if (sz == 2'd0) begin
                v = (w >> (8 * off)) & 32'hFF;
                if (sg && v >= 32'd128) v = v - 32'd256;
            end else if (sz == 2'd1) begin
                v = (w >> (8 * off)) & 32'hFFFF;
                if (sg && v >= 32'd32768) v = v - 32'd65536;
            end else begin
                v = w;
            end
            exp_rd = v;
        end else if (!err && we) begin
            exp_we_cnt = 1;
            if (sz == 2'd2) begin
                ref_mem[idx] = wd;
            end else begin
                exp_lat = 3;
                mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
                ref_mem[idx] = (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            end
        end

        @(negedge clk);
        check_val("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        lat = 0; we_cnt = 0; got = 1'b0; got_rd = 32'd0; got_err = 1'b0;
        while (lat < 8 && !got) begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (mem_we) we_cnt++;
            if (resp_valid) begin
                got = 1'b1; got_rd = resp_rdata; got_err = resp_err;
            end
        end
        check_val("resp_seen", {31'd0, got}, 32'd1);
        check_val("latency", lat, exp_lat);
        check_val("rdata", got_rd, exp_rd);
        check_val("err", {31'd0, got_err}, {31'd0, err});
        check_val("mem_we_cycles", we_cnt, exp_we_cnt);
        @(negedge clk);
        check_val("resp_pulse_end", {31'd0, resp_valid}, 32'd0);
        check_val("mem_word", dmem[idx], ref_mem[idx]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 16'd0; req_wdata = 32'd0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_val("rst_rdata", resp_rdata, 32'd0);
        check_val("rst_err", {31'd0, resp_err}, 32'd0);
        check_val("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_val("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check_val("rst_mem_d", mem_d, 32'd0);
        rst = 1'b0; clr = 1'b0;

        // word store / load round trip
        run_req(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF);
        run_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'd0);
        // sub-word loads
        run_req(1'b1, 2'd2, 1'b0, 16'h0010, 32'h11223344);
        run_req(1'b0, 2'd0, 1'b1, 16'h0013, 32'd0);
        run_req(1'b0, 2'd0, 1'b0, 16'h0010, 32'd0);
        run_req(1'b1, 2'd2, 1'b0, 16'h0010, 32'h80001234);
        run_req(1'b0, 2'd1, 1'b1, 16'h0012, 32'd0);
        run_req(1'b0, 2'd0, 1'b1, 16'h0012, 32'd0);
        // byte store read-modify-write
        run_req(1'b1, 2'd2, 1'b0, 16'h0010, 32'hAABBCCDD);
        run_req(1'b1, 2'd0, 1'b0, 16'h0011, 32'h00000055);
        run_req(1'b1, 2'd1, 1'b0, 16'h0012, 32'hFFFF9876);
        // error cases
        run_req(1'b0, 2'd2, 1'b0, 16'h0012, 32'd0);
        run_req(1'b1, 2'd1, 1'b0, 16'h0011, 32'h12345678);
        run_req(1'b0, 2'd3, 1'b1, 16'h0010, 32'd0);
        run_req(1'b1, 2'd3, 1'b0, 16'h0010, 32'hCAFEF00D);
        // out-of-range word (error or alias depending on build)
        run_req(1'b1, 2'd2, 1'b0, 16'h0000, 32'h0BADF00D);
        run_req(1'b0, 2'd2, 1'b0, 16'h1000, 32'd0);

        // reset landing in WRITE of a byte store must commit nothing
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 16'h0010; req_wdata = 32'h000000EE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_val("write_state_we", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("rst_gates_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_val("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check_val("post_rst_resp", {31'd0, resp_valid}, 32'd0);
        check_val("post_rst_mem", dmem[4], ref_mem[4]);

        for (int n = 0; n < 250; n++) begin
            logic [15:0] a;
            logic [1:0]  sz;
            if ($urandom_range(0, 7) == 0) a = 16'($urandom);
            else                           a = 16'($urandom_range(0, 127));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            run_req(1'($urandom), sz, 1'($urandom), a, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
